tick_gen: RTL and testbench

Parametrised multi-channel tick generator that replaces the bare free-running divider counter as the design's timing source. Provides NCH independent, runtime-programmable divide-by-N enable strobes (snake step rate, key-scan rate, blink rate, etc.) plus a 50%-duty square output per channel, all in the `clk` domain. It also keeps a free-running `clkdiv` count so existing consumers of divider bits can connect without change.

---
 rtl/tick_gen_pkg.sv | 19 +
 rtl/tick_gen_if.sv | 26 ++
 rtl/tick_chan.sv | 73 +++++++
 rtl/tick_gen.sv | 51 +++++
 tb/tb_tick_gen.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/tick_gen_pkg.sv
// Shared constants and helpers for the multi-channel tick generator.
// Divide constants assume the 100 MHz board clock.
package tick_gen_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_NCH   = 4;

  localparam logic [31:0] DIV_1KHZ  = 32'd100_000;
  localparam logic [31:0] DIV_100HZ = 32'd1_000_000;
  localparam logic [31:0] DIV_10HZ  = 32'd10_000_000;
  localparam logic [31:0] DIV_4HZ   = 32'd25_000_000;
  localparam logic [31:0] DIV_1HZ   = 32'd100_000_000;

  // A single channel still needs a 1-bit select so the port never collapses.
  function automatic int sel_width(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

endpackage

// File: rtl/tick_gen_if.sv
// Control/strobe bundle of tick_gen: divide-value writes in, ticks and
// square waves out, plus the legacy free-running divider count.
interface tick_gen_if #(
  parameter int WIDTH = 32,
  parameter int NCH   = 4,
  parameter int SELW  = 2
);
  logic             en;
  logic             restart;
  logic             div_we;
  logic [SELW-1:0]  div_sel;
  logic [WIDTH-1:0] div_val;
  logic [NCH-1:0]   tick;
  logic [NCH-1:0]   square;
  logic [WIDTH-1:0] clkdiv;

  modport master (
    output en, restart, div_we, div_sel, div_val,
    input  tick, square, clkdiv
  );

  modport slave (
    input  en, restart, div_we, div_sel, div_val,
    output tick, square, clkdiv
  );
endinterface

// File: rtl/tick_chan.sv
// One tick channel: programmable divide-by-N strobe with a shadowed divide
// value that only takes effect on a period boundary, plus a toggling square.
module tick_chan #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_DIV = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             restart,
  input  logic             we,
  input  logic [WIDTH-1:0] wval,
  output logic             tick,
  output logic             square
);

  logic [WIDTH-1:0] div_q;
  logic [WIDTH-1:0] div_sh_q;
  logic [WIDTH-1:0] cnt_q;
  logic             pend_q;
  logic             active;
  logic             terminal;

  assign active   = (div_q != '0);
  assign terminal = active && en && !restart && (cnt_q == div_q - WIDTH'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q    <= RESET_DIV;
      div_sh_q <= RESET_DIV;
      pend_q   <= 1'b0;
      cnt_q    <= '0;
      tick     <= 1'b0;
      square   <= 1'b0;
    end else begin
      if (restart) begin
        cnt_q  <= '0;
        tick   <= 1'b0;
        square <= 1'b0;
      end else if (!active) begin
        cnt_q <= '0;
        tick  <= 1'b0;
      end else if (terminal) begin
        cnt_q  <= '0;
        tick   <= 1'b1;
        square <= ~square;
      end else if (en) begin
        cnt_q <= cnt_q + WIDTH'(1);
        tick  <= 1'b0;
      end else begin
        tick <= 1'b0;
      end

      // An idle channel has no period to finish, so a write starts it at once;
      // otherwise the new value waits in the shadow for the next wrap.
      if (we && !active) begin
        div_q    <= wval;
        div_sh_q <= wval;
        pend_q   <= 1'b0;
      end else begin
        if (terminal && pend_q) begin
          div_q  <= div_sh_q;
          pend_q <= 1'b0;
        end
        if (we) begin
          div_sh_q <= wval;
          pend_q   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/tick_gen.sv
// Multi-channel tick generator: NCH independent divide-by-N strobes plus the
// free-running clkdiv count kept for existing divider-bit consumers.
module tick_gen
  import tick_gen_pkg::*;
#(
  parameter int               WIDTH     = DEF_WIDTH,
  parameter int               NCH       = DEF_NCH,
  parameter logic [WIDTH-1:0] RESET_DIV = '0,
  parameter int               SELW      = sel_width(NCH)
) (
  input  logic      clk,
  input  logic      rst,
  tick_gen_if.slave bus
);

  logic [WIDTH-1:0] clkdiv_q;
  logic             sel_ok;
  logic [NCH-1:0]   we_vec;

  always_ff @(posedge clk) begin
    if (rst) begin
      clkdiv_q <= '0;
    end else begin
      clkdiv_q <= clkdiv_q + WIDTH'(1);
    end
  end

  assign bus.clkdiv = clkdiv_q;

  // Selects beyond the last channel are dropped rather than aliased.
  assign sel_ok = (32'(bus.div_sel) < NCH);

  for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
    assign we_vec[gi] = bus.div_we && sel_ok && (bus.div_sel == SELW'(gi));

    tick_chan #(
      .WIDTH     (WIDTH),
      .RESET_DIV (RESET_DIV)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .en      (bus.en),
      .restart (bus.restart),
      .we      (we_vec[gi]),
      .wval    (bus.div_val),
      .tick    (bus.tick[gi]),
      .square  (bus.square[gi])
    );
  end

endmodule

// File: tb/tb_tick_gen.sv
// Directed bench for tick_gen: a 4-channel instance idle at reset and a
// 3-channel instance that resets to divide-by-2.
module tb_tick_gen;

  logic clk;
  logic rst;

  tick_gen_if #(.WIDTH(32), .NCH(4), .SELW(2)) b0 ();
  tick_gen_if #(.WIDTH(32), .NCH(3), .SELW(2)) b3 ();

  tick_gen #(.WIDTH(32), .NCH(4), .RESET_DIV(32'd0), .SELW(2)) u0 (
    .clk (clk),
    .rst (rst),
    .bus (b0)
  );

  tick_gen #(.WIDTH(32), .NCH(3), .RESET_DIV(32'd2), .SELW(2)) u3 (
    .clk (clk),
    .rst (rst),
    .bus (b3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr0(input int sel, input int val);
    b0.div_we  = 1'b1;
    b0.div_sel = 2'(sel);
    b0.div_val = 32'(val);
    step();
    b0.div_we  = 1'b0;
  endtask

  logic [31:0] cap_t, cap_s;
  logic [3:0]  acc_t, acc_s;
  logic [17:0] cap3, exp3;

  initial begin
    rst = 1'b1;
    b0.en = 1'b1; b0.restart = 1'b0; b0.div_we = 1'b0; b0.div_sel = '0; b0.div_val = '0;
    b3.en = 1'b1; b3.restart = 1'b0; b3.div_we = 1'b0; b3.div_sel = '0; b3.div_val = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // idle after reset: no ticks, clkdiv counts cycles
    acc_t = '0; acc_s = '0;
    for (int k = 0; k < 20; k++) begin
      step();
      acc_t |= b0.tick;
      acc_s |= b0.square;
    end
    chk("rst_tick", 64'(acc_t), 64'h0);
    chk("rst_square", 64'(acc_s), 64'h0);
    chk("clkdiv_20", 64'(b0.clkdiv), 64'd20);

    // ch0 enabled at 4 from idle
    wr0(0, 4);
    cap_t = '0; cap_s = '0;
    for (int k = 0; k < 12; k++) begin
      step();
      cap_t[k] = b0.tick[0];
      cap_s[k] = b0.square[0];
    end
    chk("ch0_ticks", 64'(cap_t), 64'b1000_1000_1000);
    chk("ch0_square", 64'(cap_s), 64'b1000_0111_1000);

    // ch1 at 5, rewritten to 3 mid-period
    wr0(1, 5);
    step();
    wr0(1, 3);
    cap_t = '0;
    for (int k = 0; k < 10; k++) begin
      step();
      cap_t[k] = b0.tick[1];
    end
    chk("ch1_midwrite", 64'(cap_t), 64'b01_0010_0100);

    // write on the terminal edge: one more 3-period, then 2
    step();
    wr0(1, 2);
    chk("ch1_term_tick", 64'(b0.tick[1]), 64'd1);
    cap_t = '0;
    for (int k = 0; k < 8; k++) begin
      step();
      cap_t[k] = b0.tick[1];
    end
    chk("ch1_termwrite", 64'(cap_t), 64'b0101_0100);

    // ch2 at 3, en low for 4 cycles mid-period
    wr0(2, 3);
    cap_t = '0;
    for (int k = 0; k < 4; k++) begin
      step();
      cap_t[k] = b0.tick[2];
    end
    chk("ch2_first", 64'(cap_t), 64'b0100);
    b0.en = 1'b0;
    cap_t = '0; cap_s = '0;
    for (int k = 0; k < 8; k++) begin
      step();
      cap_t[k] = b0.tick[2];
      cap_s[k] = b0.square[2];
      if (k == 3) b0.en = 1'b1;
    end
    chk("ch2_stall_tick", 64'(cap_t), 64'b0010_0000);
    chk("ch2_stall_sq", 64'(cap_s), 64'b0001_1111);

    // restart with ch0 at cnt 2 of 4
    b0.restart = 1'b1;
    step();
    b0.restart = 1'b0;
    repeat (6) step();
    chk("ch0_sq_prerst", 64'(b0.square[0]), 64'd1);
    b0.restart = 1'b1;
    step();
    b0.restart = 1'b0;
    chk("restart_tick", 64'(b0.tick), 64'h0);
    chk("restart_sq", 64'(b0.square), 64'h0);
    cap_t = '0;
    for (int k = 0; k < 4; k++) begin
      step();
      cap_t[k] = b0.tick[0];
    end
    chk("ch0_after_restart", 64'(cap_t), 64'b1000);

    // ch3 at divide-by-1, then stalled, then disabled by writing 0
    wr0(3, 1);
    cap_t = '0; cap_s = '0;
    for (int k = 0; k < 5; k++) begin
      step();
      cap_t[k] = b0.tick[3];
      cap_s[k] = b0.square[3];
    end
    chk("ch3_div1_tick", 64'(cap_t), 64'b11111);
    chk("ch3_div1_sq", 64'(cap_s), 64'b10101);
    b0.en = 1'b0;
    step();
    chk("ch3_en0_tick", 64'(b0.tick[3]), 64'd0);
    chk("ch3_en0_sq", 64'(b0.square[3]), 64'd1);
    b0.en = 1'b1;
    wr0(3, 0);
    chk("ch3_wr0_tick", 64'(b0.tick[3]), 64'd1);
    cap_t = '0; cap_s = '0;
    for (int k = 0; k < 3; k++) begin
      step();
      cap_t[k] = b0.tick[3];
      cap_s[k] = b0.square[3];
    end
    chk("ch3_disable_tick", 64'(cap_t), 64'b001);
    chk("ch3_disable_sq", 64'(cap_s), 64'b111);

    // reset mid-run; u3 also gets an out-of-range write
    rst = 1'b1;
    step();
    chk("rst_mid_tick", 64'(b0.tick), 64'h0);
    chk("rst_mid_sq", 64'(b0.square), 64'h0);
    chk("rst_mid_clkdiv", 64'(b0.clkdiv), 64'h0);
    chk("rst_mid_u3_tick", 64'(b3.tick), 64'h0);
    rst = 1'b0;
    b3.div_we  = 1'b1;
    b3.div_sel = 2'd3;
    b3.div_val = 32'd7;
    acc_t = '0; cap3 = '0; exp3 = '0;
    for (int k = 0; k < 6; k++) begin
      step();
      b3.div_we = 1'b0;
      acc_t |= b0.tick;
      cap3[k*3 +: 3] = b3.tick;
      exp3[k*3 +: 3] = (k % 2 == 1) ? 3'b111 : 3'b000;
    end
    chk("rst_mid_idle", 64'(acc_t), 64'h0);
    chk("u3_badsel", 64'(cap3), 64'(exp3));

    // clkdiv wrap
    force u0.clkdiv_q = 32'hFFFF_FFFF;
    #1;
    chk("clkdiv_pre_wrap", 64'(b0.clkdiv), 64'hFFFF_FFFF);
    release u0.clkdiv_q;
    step();
    chk("clkdiv_wrap", 64'(b0.clkdiv), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
